// File: rtl/serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_deser
//  Description : Serial-to-word frame deserializer. Hunts for a sync word on
//                a bit-serial stream, then assembles FRAME_LEN words of WIDTH
//                bits (MSB first) into a 2-entry valid/ready output buffer.
//                Lock is dropped after each frame and the hunt restarts.
//  Options     : DESER_PARITY_EN - each data word is followed by one even
//                parity bit; bad words are discarded and flagged on
//                parity_err. Without it parity_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_deser #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC      = WIDTH'(8'hAC),
    parameter int               FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             frame_done,
    output logic             overflow,
    output logic             parity_err
);

    // Serial bits that make up one word while locked (data plus optional parity)
`ifdef DESER_PARITY_EN
    localparam int c_BITS = WIDTH + 1;
`else
    localparam int c_BITS = WIDTH;
`endif
    localparam int c_BCW  = $clog2(c_BITS);
    localparam int c_WCW  = $clog2(FRAME_LEN + 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_window;
    logic [WIDTH-1:0] w_window_next;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_next;
    logic [c_BCW-1:0] r_bitcnt;
    logic [c_BCW-1:0] w_bitcnt_next;
    logic [c_WCW-1:0] r_wordcnt;
    logic [c_WCW-1:0] w_wordcnt_next;

    logic [WIDTH-1:0] w_shift_win;
    logic [WIDTH-1:0] w_shift_word;
    logic             w_last_bit;
    logic             w_last_word;
    logic             w_complete;
    logic             w_frame_end;
    logic             w_push;
    logic             w_perr;
    logic [WIDTH-1:0] w_done_word;

    // Output buffer storage and bookkeeping
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_overflow;
    logic             r_frame_done;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;

    assign w_shift_win  = {r_window[WIDTH-2:0], ser_in};
    assign w_shift_word = {r_word[WIDTH-2:0], ser_in};
    assign w_last_bit   = (r_bitcnt == c_BCW'(c_BITS - 1));
    assign w_last_word  = (r_wordcnt == c_WCW'(FRAME_LEN - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: sync hunt, word assembly and frame termination
    always_comb begin
        w_state_next   = r_state;
        w_window_next  = r_window;
        w_word_next    = r_word;
        w_bitcnt_next  = r_bitcnt;
        w_wordcnt_next = r_wordcnt;
        w_complete     = 1'b0;
        w_frame_end    = 1'b0;
        w_push         = 1'b0;
        w_perr         = 1'b0;
        w_done_word    = w_shift_word;

        case (r_state)
            HUNT: begin
                if (ser_valid) begin
                    w_window_next = w_shift_win;
                    if (w_shift_win == SYNC) begin
                        w_state_next   = LOCKED;
                        w_bitcnt_next  = '0;
                        w_wordcnt_next = '0;
                    end
                end
            end
            LOCKED: begin
                if (ser_valid) begin
`ifdef DESER_PARITY_EN
                    // The final serial bit of a word is its parity bit; the
                    // data bits are already complete in r_word by then.
                    if (w_last_bit) begin
                        w_complete    = 1'b1;
                        w_done_word   = r_word;
                        w_bitcnt_next = '0;
                        if ((^r_word) ^ ser_in) begin
                            w_perr = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else begin
                        w_word_next   = w_shift_word;
                        w_bitcnt_next = r_bitcnt + c_BCW'(1);
                    end
`else
                    w_word_next = w_shift_word;
                    if (w_last_bit) begin
                        w_complete    = 1'b1;
                        w_done_word   = w_shift_word;
                        w_push        = 1'b1;
                        w_bitcnt_next = '0;
                    end else begin
                        w_bitcnt_next = r_bitcnt + c_BCW'(1);
                    end
`endif
                    // Every completed word counts, even if dropped or bad
                    if (w_complete) begin
                        if (w_last_word) begin
                            w_frame_end    = 1'b1;
                            w_state_next   = HUNT;
                            w_window_next  = '0;
                            w_wordcnt_next = '0;
                        end else begin
                            w_wordcnt_next = r_wordcnt + c_WCW'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_next = HUNT;
            end
        endcase
    end

    // Datapath registers: sync window, word shifter and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window  <= '0;
            r_word    <= '0;
            r_bitcnt  <= '0;
            r_wordcnt <= '0;
        end else begin
            r_window  <= w_window_next;
            r_word    <= w_word_next;
            r_bitcnt  <= w_bitcnt_next;
            r_wordcnt <= w_wordcnt_next;
        end
    end

    // A full buffer still accepts a push when the head leaves on the same edge
    assign w_pop    = (r_count != 2'd0) && out_ready;
    assign w_accept = w_push && ((r_count != 2'd2) || w_pop);
    assign w_drop   = w_push && !w_accept;

    // Two-entry output buffer with sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_done_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // One-cycle end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end

`ifdef DESER_PARITY_EN
    logic r_parity_err;

    // One-cycle parity error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign out_data   = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != 2'd0);
    assign locked     = (r_state == LOCKED);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_deser
//  Description : Directed self-checking bench for serial_frame_deser.
//                Parity-specific steps are built when DESER_PARITY_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deser;

    localparam int WIDTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             ser_in    = 1'b0;
    logic             ser_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             locked;
    logic             frame_done;
    logic             overflow;
    logic             parity_err;

    int n_cmp = 0;
    int n_err = 0;

    serial_frame_deser #(
        .WIDTH     (WIDTH),
        .SYNC      (8'hAC),
        .FRAME_LEN (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, return 1 time unit after the sampling edge
    task automatic send_bit(input logic b, input logic v, input logic r);
        @(negedge clk);
        ser_in    = b;
        ser_valid = v;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        send_bit(1'b1, 1'b0, r);
    endtask

    task automatic send_sync(input logic r);
        logic [WIDTH-1:0] s;
        s = 8'hAC;
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(s[i], 1'b1, r);
    endtask

    // Data word (plus parity when enabled); rl is out_ready on the final bit
    task automatic send_word(input logic [WIDTH-1:0] w, input logic r, input logic rl);
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
            send_bit(w[i], 1'b1, r);
`else
            send_bit(w[i], 1'b1, (i == 0) ? rl : r);
`endif
        end
`ifdef DESER_PARITY_EN
        send_bit(^w, 1'b1, rl);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c3;
        logic [WIDTH-1:0] bad;

        // 1. Reset held with ser_valid toggling
        for (int i = 0; i < 4; i++) send_bit(1'b1, i[0], 1'b1);
        chk("rst_valid", out_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk("rst_ovf", overflow, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_valid2", out_valid, 0);

        // 2. Nominal frame with out_ready high
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(1'b0, 1'b1, 1'b1);
        s = 8'hAC;
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(s[i], 1'b1, 1'b1);
        chk("nom_prelock", locked, 0);
        send_bit(s[0], 1'b1, 1'b1);
        chk("nom_lock", locked, 1);
        chk("nom_nov", out_valid, 0);
        send_word(8'hF0, 1'b1, 1'b1);
        chk("nom_v0", out_valid, 1);
        chk("nom_d0", out_data, 32'hF0);
        send_word(8'h0F, 1'b1, 1'b1);
        chk("nom_d1", out_data, 32'h0F);
        send_word(8'h55, 1'b1, 1'b1);
        chk("nom_d2", out_data, 32'h55);
        chk("nom_fd_early", frame_done, 0);
        send_word(8'hAA, 1'b1, 1'b1);
        chk("nom_d3", out_data, 32'hAA);
        chk("nom_v3", out_valid, 1);
        chk("nom_fd", frame_done, 1);
        chk("nom_unlock", locked, 0);
        idle(1'b1);
        chk("nom_fd_off", frame_done, 0);
        chk("nom_empty", out_valid, 0);
        chk("nom_ovf", overflow, 0);

        // 3. Back-pressure and overflow
        send_sync(1'b0);
        chk("bp_lock", locked, 1);
        send_word(8'h11, 1'b0, 1'b0);
        chk("bp_v", out_valid, 1);
        chk("bp_d11", out_data, 32'h11);
        send_word(8'h22, 1'b0, 1'b0);
        chk("bp_hold", out_data, 32'h11);
        chk("bp_noovf", overflow, 0);
        send_word(8'h33, 1'b0, 1'b0);
        chk("bp_ovf", overflow, 1);
        send_word(8'h44, 1'b0, 1'b0);
        chk("bp_fd", frame_done, 1);
        chk("bp_d_stable", out_data, 32'h11);
        idle(1'b1);
        chk("bp_d22", out_data, 32'h22);
        chk("bp_v22", out_valid, 1);
        idle(1'b1);
        chk("bp_drained", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // 4. Push into full buffer on the same edge as a pop
        do_reset();
        idle(1'b0);
        chk("pp_ovf_clr", overflow, 0);
        send_sync(1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b1);
        chk("pp_head", out_data, 32'h22);
        chk("pp_v", out_valid, 1);
        chk("pp_ovf", overflow, 0);
        idle(1'b1);
        chk("pp_order", out_data, 32'h33);
        idle(1'b1);
        chk("pp_empty", out_valid, 0);

        // 5. Gapped sync, then asynchronous reset mid-word
        do_reset();
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(s[i], 1'b1, 1'b1);
            send_bit(~s[i], 1'b0, 1'b1);
        end
        chk("gap_lock", locked, 1);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("gap_d", out_data, 32'h5A);
        c3 = 8'hC3;
        for (int i = WIDTH - 1; i >= WIDTH - 5; i--) send_bit(c3[i], 1'b1, 1'b0);
        chk("mid_v", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lock", locked, 0);
        chk("mid_rst_v", out_valid, 0);
        chk("mid_rst_d", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hC3, 1'b1, 1'b1);
        chk("post_nolock", locked, 0);
        chk("post_nov", out_valid, 0);
        send_sync(1'b1);
        chk("post_lock", locked, 1);
        send_word(8'h3C, 1'b1, 1'b1);
        chk("post_d", out_data, 32'h3C);
        chk("post_perr", parity_err, 0);

`ifdef DESER_PARITY_EN
        // 6. Parity: good word, bad word, frame count includes the bad word
        do_reset();
        send_sync(1'b1);
        send_word(8'hF0, 1'b1, 1'b1);
        chk("par_d", out_data, 32'hF0);
        chk("par_ok", parity_err, 0);
        bad = 8'h01;
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(bad[i], 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        chk("par_err", parity_err, 1);
        chk("par_drop", out_valid, 0);
        idle(1'b1);
        chk("par_pulse", parity_err, 0);
        send_word(8'h55, 1'b1, 1'b1);
        chk("par_nofd", frame_done, 0);
        send_word(8'hAA, 1'b1, 1'b1);
        chk("par_fd", frame_done, 1);
        chk("par_ovf", overflow, 0);
`else
        bad = 8'h00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_deser.md
Name: serial_frame_deser

Overview:
Downstream neighbour of the byte shifter: consumes its serial bit stream and hunts for a sync byte. Once locked, it assembles a fixed number of WIDTH-bit words, MSB first. Completed words go through a 2-entry output buffer with a valid/ready handshake to the next consumer. After FRAME_LEN words it drops lock and hunts again.

Parameters:
WIDTH, 8, word width in bits (>=2)
SYNC, 8'hAC, sync pattern, WIDTH bits, must be nonzero
FRAME_LEN, 4, data words per frame after sync (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ser_in  input  1  serial data bit
ser_valid  input  1  ser_in sampled on the clk edge only when high
out_data  output  WIDTH  head-of-buffer word
out_valid  output  1  buffer non-empty
out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
locked  output  1  high while in LOCKED state
frame_done  output  1  one-cycle pulse when the last word of a frame completes
overflow  output  1  sticky: a word was dropped because the buffer was full
parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 without the option)

Behaviour:
- Reset: clk and reset are one clock, asynchronous active-low rst_n.
  - On reset, state goes to HUNT; window, bit and word counters, and buffer clear.
  - out_valid, locked, frame_done, overflow and parity_err are all 0; out_data is 0.
  - Reset mid-word or mid-frame discards the partial word and all buffered words.
- HUNT:
  - Each valid bit shifts the WIDTH-bit window left, with the new bit entering at LSB.
  - When the updated window equals SYNC, move to LOCKED on that edge. locked is high from the next cycle.
  - Bit counter and word counter go to 0.
- LOCKED:
  - Each valid bit shifts into the word register, MSB first.
  - On the WIDTH-th bit the word is complete and is pushed to the buffer. Bits of the next word may arrive on the very next edge.
  - The word counter increments on every completed word, including dropped ones.
  - When it reaches FRAME_LEN: pulse frame_done, return to HUNT, clear the window to 0.
- Sync detection:
  - No sync detection occurs while LOCKED; sync patterns inside data are ignored.
  - Overlapping sync detection in HUNT is natural, since the window slides bit by bit.
- ser_valid low: nothing advances; gaps of any length are legal.
- Buffer: 2-entry FIFO.
  - A push is accepted if count<2, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set (sticky until reset).
  - Push into an empty buffer: out_valid and out_data update on the same edge the word completes, so visible the following cycle. Latency is 1 cycle from the last bit edge.
  - Pop with count=1 and no push: out_valid falls after the edge.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - out_data is stable while out_valid & !out_ready.
- frame_done is asserted regardless of whether the final word was dropped.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined:
  - In LOCKED, each word is followed by one extra parity bit, so a word is complete after WIDTH+1 valid bits.
  - Even parity: the XOR of the WIDTH data bits and the parity bit must be 0.
  - On mismatch, the word is not pushed, parity_err pulses one cycle, and the word still counts toward FRAME_LEN.
  - Overflow is evaluated only for parity-good words.
- Undefined: words are WIDTH bits, and parity_err is constant 0.

Test Plan:
1. Reset: hold rst_n=0 with ser_valid toggling, then release -> out_valid=0, locked=0, overflow=0, frame_done=0, no transfers.
2. Nominal frame: continuous valid bits 0x00, 0xAC, 0xF0, 0x0F, 0x55, 0xAA, out_ready=1.
   - locked rises the cycle after the last AC bit.
   - Outputs are F0, 0F, 55, AA in order, each out_valid one cycle after its last bit.
   - frame_done pulses with AA; locked then falls.
3. Back-pressure: sync 0xAC, then 0x11, 0x22, 0x33, 0x44 with out_ready=0.
   - Buffer holds 11, 22; 33 and 44 are dropped; overflow=1.
   - Raise out_ready: 11 then 22 drain, and out_valid falls.
4. Full simultaneous push/pop: buffer holds 11, 22; word 33 completes on the same edge as out_ready=1 -> 11 leaves, buffer holds 22, 33, overflow stays 0.
5. Gaps and mid-word reset:
   - Send the sync bits with ser_valid low on alternate cycles -> lock is still achieved.
   - After 5 bits of word 0xC3, pulse rst_n low -> locked=0 and out_valid=0 immediately. A new 0xAC is needed before any output.
6. DESER_PARITY_EN: sync, then 0xF0+p0 and 0x01+p0 (bad) -> F0 output; 0x01 dropped with parity_err pulse; word count advances to 2.
